// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave over a word-addressed SRAM; independent write (AW/W/B) and read (AR/R) FSMs, one outstanding each.
// Optional address range checking (SLVERR, no memory effect) under `AXI_SLV_RANGE_CHECK_EN.
module axi_lite_sram_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              awvalid,
  output logic              awready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

  wr_state_t wr_state;
  rd_state_t rd_state;

  logic [31:0] mem [DEPTH_WORDS];

  logic             aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0] aw_idx_in, ar_idx_in;
  logic             aw_err_in, ar_err_in;

  logic             aw_held, w_held;
  logic [IDX_W-1:0] aw_idx_q;
  logic             aw_err_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;

  logic             have_aw, have_w, wr_commit;
  logic [IDX_W-1:0] cm_idx;
  logic             cm_err;
  logic [31:0]      cm_data;
  logic [3:0]       cm_strb;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign ar_hs = arvalid && arready;

  assign aw_idx_in = IDX_W'((awaddr - BASE_ADDR) >> 2);
  assign ar_idx_in = IDX_W'((araddr - BASE_ADDR) >> 2);

`ifdef AXI_SLV_RANGE_CHECK_EN
  assign aw_err_in = ((awaddr - BASE_ADDR) >> (IDX_W + 2)) != '0;
  assign ar_err_in = ((araddr - BASE_ADDR) >> (IDX_W + 2)) != '0;
`else
  assign aw_err_in = 1'b0;
  assign ar_err_in = 1'b0;
`endif

  // The commit uses whichever of address/data was captured earlier, or the live bus if it arrives now.
  assign have_aw   = aw_held || aw_hs;
  assign have_w    = w_held || w_hs;
  assign wr_commit = (wr_state == WR_IDLE) && have_aw && have_w;
  assign cm_idx    = aw_held ? aw_idx_q : aw_idx_in;
  assign cm_err    = aw_held ? aw_err_q : aw_err_in;
  assign cm_data   = w_held ? wdata_q : wdata;
  assign cm_strb   = w_held ? wstrb_q : wstrb;

  // Storage is not reset; a write is suppressed while reset is asserted.
  always_ff @(posedge i_clk) begin
    if (i_rstn && wr_commit && !cm_err) begin
      for (int b = 0; b < 4; b++) begin
        if (cm_strb[b]) mem[cm_idx][8*b +: 8] <= cm_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      aw_err_q <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
      bresp    <= 2'b00;
    end else if (wr_state == WR_IDLE) begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= aw_idx_in;
        aw_err_q <= aw_err_in;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (wr_commit) begin
        wr_state <= WR_RESP;
        awready  <= 1'b0;
        wready   <= 1'b0;
        bvalid   <= 1'b1;
        bresp    <= {cm_err, 1'b0};
      end else begin
        awready <= !have_aw;
        wready  <= !have_w;
      end
    end else if (bready) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awready  <= 1'b1;
      wready   <= 1'b1;
      bvalid   <= 1'b0;
    end
  end

  // Read samples the array with a non-blocking view, so a same-edge write returns old data.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
      rdata    <= '0;
      rresp    <= 2'b00;
    end else if (rd_state == RD_IDLE) begin
      if (ar_hs) begin
        rd_state <= RD_DATA;
        arready  <= 1'b0;
        rvalid   <= 1'b1;
        rdata    <= ar_err_in ? 32'h0 : mem[ar_idx_in];
        rresp    <= {ar_err_in, 1'b0};
      end
    end else if (rready) begin
      rd_state <= RD_IDLE;
      arready  <= 1'b1;
      rvalid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed self-checking bench for axi_lite_sram_slave (default parameters).
module tb_axi_lite_sram_slave;
  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  int n_checks = 0;
  int n_errors = 0;

  axi_lite_sram_slave dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    logic aw_ok, w_ok;
    int   n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_ok = awready; w_ok = wready;
      tick();
      if (aw_ok) awvalid = 1'b0;
      if (w_ok) wvalid = 1'b0;
      n++;
    end
    lat = 0;
    while (!bvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("wr_bvalid", {31'b0, bvalid}, 32'h1);
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    logic ar_ok;
    int   n;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (arvalid && n < 20) begin
      ar_ok = arready;
      tick();
      if (ar_ok) arvalid = 1'b0;
      n++;
    end
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("rd_rvalid", {31'b0, rvalid}, 32'h1);
    d = rdata; resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] d, held;
    int          lat;

    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; rready = 0;

    repeat (2) @(posedge i_clk);
    #1;
    check("rst_awready", {31'b0, awready}, 32'h1);
    check("rst_wready",  {31'b0, wready},  32'h1);
    check("rst_arready", {31'b0, arready}, 32'h1);
    check("rst_bvalid",  {31'b0, bvalid},  32'h0);
    check("rst_bresp",   {30'b0, bresp},   32'h0);
    check("rst_rvalid",  {31'b0, rvalid},  32'h0);
    check("rst_rdata",   rdata,            32'h0);
    check("rst_rresp",   {30'b0, rresp},   32'h0);
    i_rstn = 1'b1;
    tick();

    // Simultaneous AW+W, then read back
    do_write(32'h10, 32'hDEADBEEF, 4'hF, resp, lat);
    check("t1_wlat", lat, 0);
    check("t1_bresp", {30'b0, resp}, 32'h0);
    do_read(32'h10, d, resp, lat);
    check("t1_rlat", lat, 0);
    check("t1_rdata", d, 32'hDEADBEEF);
    check("t1_rresp", {30'b0, resp}, 32'h0);

    // W three cycles ahead of AW, partial strobes
    wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_no_bvalid", {31'b0, bvalid}, 32'h0);
      check("t2_wready_lo", {31'b0, wready}, 32'h0);
      check("t2_awready_hi", {31'b0, awready}, 32'h1);
      if (i < 2) tick();
    end
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t2_bvalid", {31'b0, bvalid}, 32'h1);
    check("t2_bresp", {30'b0, bresp}, 32'h0);
    tick();
    check("t2_bdone", {31'b0, bvalid}, 32'h0);
    bready = 1'b0;
    do_read(32'h10, d, resp, lat);
    check("t2_rdata", d, 32'hDE22BE44);

    // R backpressure for five cycles
    araddr = 32'h10; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    held = rdata;
    check("t3_rdata", held, 32'hDE22BE44);
    for (int i = 0; i < 5; i++) begin
      check("t3_rvalid", {31'b0, rvalid}, 32'h1);
      check("t3_stable", rdata, held);
      check("t3_arready", {31'b0, arready}, 32'h0);
      tick();
    end
    rready = 1'b1;
    check("t3_rvalid6", {31'b0, rvalid}, 32'h1);
    tick();
    rready = 1'b0;
    check("t3_rdone", {31'b0, rvalid}, 32'h0);
    check("t3_arready_back", {31'b0, arready}, 32'h1);

    // Read in the same cycle the write commits: old data returned
    do_write(32'h20, 32'hAAAAAAAA, 4'hF, resp, lat);
    awaddr = 32'h20; wdata = 32'h55555555; wstrb = 4'hF; araddr = 32'h20;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("t4_rvalid", {31'b0, rvalid}, 32'h1);
    check("t4_bvalid", {31'b0, bvalid}, 32'h1);
    check("t4_old", rdata, 32'hAAAAAAAA);
    tick();
    bready = 1'b0; rready = 1'b0;
    check("t4_bdone", {31'b0, bvalid}, 32'h0);
    do_read(32'h20, d, resp, lat);
    check("t4_new", d, 32'h55555555);

    // One past the top of the window
    do_write(32'h0, 32'hCAFEF00D, 4'hF, resp, lat);
    do_write(32'h1000, 32'h12345678, 4'hF, resp, lat);
`ifdef AXI_SLV_RANGE_CHECK_EN
    check("t5_bresp", {30'b0, resp}, 32'h2);
    do_read(32'h1000, d, resp, lat);
    check("t5_rresp", {30'b0, resp}, 32'h2);
    check("t5_rdata", d, 32'h0);
    do_read(32'h0, d, resp, lat);
    check("t5_word0", d, 32'hCAFEF00D);
`else
    check("t5_bresp", {30'b0, resp}, 32'h0);
    do_read(32'h1000, d, resp, lat);
    check("t5_rresp", {30'b0, resp}, 32'h0);
    check("t5_rdata", d, 32'h12345678);
    do_read(32'h0, d, resp, lat);
    check("t5_word0", d, 32'h12345678);
`endif

    // Reset with a pending B, then reset with only AW held
    do_write(32'h30, 32'h0BADCAFE, 4'hF, resp, lat);
    awaddr = 32'h30; wdata = 32'h11111111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("t6_bvalid", {31'b0, bvalid}, 32'h1);
    i_rstn = 1'b0;
    #1;
    check("t6_bvalid_drop", {31'b0, bvalid}, 32'h0);
    tick();
    i_rstn = 1'b1;
    tick();
    check("t6_awready", {31'b0, awready}, 32'h1);
    check("t6_wready",  {31'b0, wready},  32'h1);
    check("t6_arready", {31'b0, arready}, 32'h1);
    awaddr = 32'h30; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t6_aw_held", {31'b0, awready}, 32'h0);
    i_rstn = 1'b0;
    tick();
    i_rstn = 1'b1;
    tick();
    check("t6_awready2", {31'b0, awready}, 32'h1);
    check("t6_bvalid2", {31'b0, bvalid}, 32'h0);
    wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    check("t6_no_stale_aw", {31'b0, bvalid}, 32'h0);
    awaddr = 32'h40; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("t6_bvalid3", {31'b0, bvalid}, 32'h1);
    tick();
    bready = 1'b0;
    do_read(32'h30, d, resp, lat);
    check("t6_word30", d, 32'h11111111);
    do_read(32'h40, d, resp, lat);
    check("t6_word40", d, 32'h99999999);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
